// File: rtl/mem_dump_pkg.sv
// Shared definitions for the memory dump controller: default widths and FSM states.
// The CHK state exists only when MEM_DUMP_CHECKSUM_EN is defined.
package mem_dump_pkg;

    localparam int unsigned DEF_ADDR_BUS  = 11;
    localparam int unsigned DEF_DATA_SIZE = 16;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        READ = 3'd1,
        SEND = 3'd2,
        DONE = 3'd3
`ifdef MEM_DUMP_CHECKSUM_EN
        , CHK = 3'd4
`endif
    } state_t;

    // Width of a byte index into a word of nb bytes; never narrower than 1 bit.
    function automatic int unsigned idx_width(input int unsigned nb);
        return (nb > 1) ? $clog2(nb) : 1;
    endfunction

endpackage

// File: rtl/mem_dump_byte_sel.sv
// Byte selection from the word register: index 0 picks the most significant byte.
module mem_dump_byte_sel
    import mem_dump_pkg::*;
#(
    parameter  int unsigned data_size = DEF_DATA_SIZE,
    localparam int unsigned NB        = data_size / 8,
    localparam int unsigned IW        = idx_width(data_size / 8)
) (
    input  logic [data_size-1:0] word,
    input  logic [IW-1:0]        byte_idx,
    output logic [7:0]           sel_byte
);

    always_comb begin
        sel_byte = '0;
        for (int unsigned i = 0; i < NB; i++) begin
            if (byte_idx == IW'(i)) begin
                sel_byte = word[(NB-1-i)*8 +: 8];
            end
        end
    end

endmodule

// File: rtl/mem_dump_ctrl.sv
// Dumps data memory words 0..Last_Addr to a byte-wide transmitter, MSB byte first.
// Define MEM_DUMP_CHECKSUM_EN to append an XOR checksum byte after the last word.
module mem_dump_ctrl
    import mem_dump_pkg::*;
#(
    parameter int unsigned addr_bus  = DEF_ADDR_BUS,
    parameter int unsigned data_size = DEF_DATA_SIZE
) (
    input  logic                 Clk,
    input  logic                 Reset,
    input  logic                 Start,
    input  logic [addr_bus-1:0]  Last_Addr,
    output logic                 Mem_Rd,
    output logic                 Mem_Wr,
    output logic [addr_bus-1:0]  Mem_Addr,
    output logic [data_size-1:0] Mem_In_Data,
    input  logic [data_size-1:0] Mem_Out_Data,
    output logic [7:0]           Tx_Data,
    output logic                 Tx_Valid,
    input  logic                 Tx_Ready,
    output logic                 Busy,
    output logic                 Done
);

    localparam int unsigned NB = data_size / 8;
    localparam int unsigned IW = idx_width(NB);
    localparam logic [IW-1:0] LAST_IDX = IW'(NB - 1);

    state_t               state;
    logic [addr_bus-1:0]  addr_cnt;
    logic [addr_bus-1:0]  last_reg;
    logic [data_size-1:0] word_reg;
    logic [IW-1:0]        byte_idx;
    logic [7:0]           sel_byte;
`ifdef MEM_DUMP_CHECKSUM_EN
    logic [7:0]           csum;
`endif

    mem_dump_byte_sel #(
        .data_size (data_size)
    ) u_byte_sel (
        .word     (word_reg),
        .byte_idx (byte_idx),
        .sel_byte (sel_byte)
    );

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state    <= IDLE;
            addr_cnt <= '0;
            last_reg <= '0;
            word_reg <= '0;
            byte_idx <= '0;
`ifdef MEM_DUMP_CHECKSUM_EN
            csum     <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (Start) begin
                        state    <= READ;
                        addr_cnt <= '0;
                        last_reg <= Last_Addr;
                        byte_idx <= '0;
`ifdef MEM_DUMP_CHECKSUM_EN
                        csum     <= '0;
`endif
                    end
                end
                READ: begin
                    word_reg <= Mem_Out_Data;
                    state    <= SEND;
                end
                SEND: begin
                    if (Tx_Ready) begin
`ifdef MEM_DUMP_CHECKSUM_EN
                        csum <= csum ^ sel_byte;
`endif
                        if (byte_idx != LAST_IDX) begin
                            byte_idx <= byte_idx + 1'b1;
                        end else if (addr_cnt == last_reg) begin
                            // Compare before incrementing so the top address never wraps.
`ifdef MEM_DUMP_CHECKSUM_EN
                            state <= CHK;
`else
                            state <= DONE;
`endif
                        end else begin
                            addr_cnt <= addr_cnt + 1'b1;
                            byte_idx <= '0;
                            state    <= READ;
                        end
                    end
                end
`ifdef MEM_DUMP_CHECKSUM_EN
                CHK: begin
                    if (Tx_Ready) begin
                        state <= DONE;
                    end
                end
`endif
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Outputs decode directly from the state register so reset clears them at once.
    always_comb begin
        Tx_Data = '0;
        case (state)
            SEND:    Tx_Data = sel_byte;
`ifdef MEM_DUMP_CHECKSUM_EN
            CHK:     Tx_Data = csum;
`endif
            default: Tx_Data = '0;
        endcase
    end

`ifdef MEM_DUMP_CHECKSUM_EN
    assign Tx_Valid = (state == SEND) || (state == CHK);
`else
    assign Tx_Valid = (state == SEND);
`endif

    assign Mem_Rd      = (state == READ);
    assign Mem_Wr      = 1'b0;
    assign Mem_Addr    = addr_cnt;
    assign Mem_In_Data = '0;
    assign Busy        = (state != IDLE);
    assign Done        = (state == DONE);

endmodule

// File: tb/tb_mem_dump_ctrl.sv
// Self-checking bench for mem_dump_ctrl: table-driven dumps, corner sequences and random runs
// compared against a byte-list reference model of the memory contents.
module tb_mem_dump_ctrl;

    localparam int unsigned AW     = 11;
    localparam int unsigned DW     = 16;
    localparam int unsigned NB     = DW / 8;
    localparam int unsigned BUDGET = 40000;
`ifdef MEM_DUMP_CHECKSUM_EN
    localparam int unsigned CHK_X  = 1;
`else
    localparam int unsigned CHK_X  = 0;
`endif

    logic          Clk = 1'b0;
    logic          Reset;
    logic          Start;
    logic [AW-1:0] Last_Addr;
    logic          Mem_Rd;
    logic          Mem_Wr;
    logic [AW-1:0] Mem_Addr;
    logic [DW-1:0] Mem_In_Data;
    logic [DW-1:0] Mem_Out_Data;
    logic [7:0]    Tx_Data;
    logic          Tx_Valid;
    logic          Tx_Ready;
    logic          Busy;
    logic          Done;

    logic [DW-1:0] mem [2**AW];

    int unsigned n_cmp  = 0;
    int unsigned n_fail = 0;

    logic [7:0]    got_q[$];
    logic [7:0]    exp_q[$];
    logic [AW-1:0] rd_q[$];
    int unsigned   done_cnt, busy_cyc, bad_wr, cyc, done_cyc, last_xfer;
    int unsigned   rmode;
    bit            prev_stall;
    logic [7:0]    prev_data;

    mem_dump_ctrl #(
        .addr_bus  (AW),
        .data_size (DW)
    ) dut (
        .Clk          (Clk),
        .Reset        (Reset),
        .Start        (Start),
        .Last_Addr    (Last_Addr),
        .Mem_Rd       (Mem_Rd),
        .Mem_Wr       (Mem_Wr),
        .Mem_Addr     (Mem_Addr),
        .Mem_In_Data  (Mem_In_Data),
        .Mem_Out_Data (Mem_Out_Data),
        .Tx_Data      (Tx_Data),
        .Tx_Valid     (Tx_Valid),
        .Tx_Ready     (Tx_Ready),
        .Busy         (Busy),
        .Done         (Done)
    );

    assign Mem_Out_Data = Mem_Rd ? mem[Mem_Addr] : '0;

    always #5 Clk = ~Clk;

    // Tx_Ready driver: 0 = always ready, 1 = toggles every 3 cycles, 2 = random.
    initial begin
        int unsigned k = 0;
        Tx_Ready = 1'b1;
        forever begin
            @(posedge Clk);
            #1;
            k++;
            case (rmode)
                0:       Tx_Ready = 1'b1;
                1:       Tx_Ready = ((k / 3) % 2) == 1;
                default: Tx_Ready = ($urandom_range(0, 99) < 60);
            endcase
        end
    end

    // Monitor: a transfer observed here completes on the following rising edge.
    initial begin
        cyc = 0;
        prev_stall = 1'b0;
        prev_data = '0;
        forever begin
            @(negedge Clk);
            cyc++;
            if (!Reset) begin
                prev_stall = 1'b0;
            end else begin
                if (prev_stall) begin
                    n_cmp++;
                    if (!(Tx_Valid && Tx_Data == prev_data)) begin
                        n_fail++;
                        $display("FAIL stall_hold: valid=%0b data=%02h expected valid=1 data=%02h",
                                 Tx_Valid, Tx_Data, prev_data);
                    end
                end
                prev_stall = Tx_Valid && !Tx_Ready;
                prev_data  = Tx_Data;
                if (Tx_Valid && Tx_Ready) begin
                    got_q.push_back(Tx_Data);
                    last_xfer = cyc;
                end
                if (Mem_Rd) rd_q.push_back(Mem_Addr);
                if (Mem_Wr || Mem_In_Data != '0) bad_wr++;
                if (Done) begin
                    done_cnt++;
                    done_cyc = cyc;
                end
                if (Busy) busy_cyc++;
            end
        end
    end

    task automatic check(input string name, input longint unsigned act, input longint unsigned exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: every word 0..last, MSB byte first, optionally followed by the XOR of all bytes.
    task automatic build_exp(input int unsigned last);
        logic [7:0]    x;
        logic [DW-1:0] w;
        exp_q.delete();
        x = '0;
        for (int unsigned a = 0; a <= last; a++) begin
            w = mem[a];
            for (int unsigned b = 0; b < NB; b++) begin
                exp_q.push_back(w[8*(NB-1-b) +: 8]);
                x = x ^ w[8*(NB-1-b) +: 8];
            end
        end
`ifdef MEM_DUMP_CHECKSUM_EN
        exp_q.push_back(x);
`endif
    endtask

    task automatic clear_mon();
        got_q.delete();
        rd_q.delete();
        done_cnt = 0;
        busy_cyc = 0;
        bad_wr   = 0;
        done_cyc = 0;
        last_xfer = 0;
    endtask

    task automatic run_dump(input string tag, input int unsigned last, input int unsigned mode,
                            input bit disturb, input int unsigned exp_bytes, input int unsigned exp_busy);
        bit seen = 1'b0;
        build_exp(last);
        rmode = mode;
        clear_mon();
        @(posedge Clk);
        #1;
        Start = 1'b1;
        Last_Addr = AW'(last);
        @(posedge Clk);
        #1;
        Start = disturb;
        Last_Addr = AW'($urandom);
        for (int unsigned c = 0; c < BUDGET; c++) begin
            @(negedge Clk);
            if (Done) begin
                seen = 1'b1;
                break;
            end
            if (disturb) Last_Addr = AW'($urandom);
        end
        Start = 1'b0;
        check({tag, "_done_seen"}, seen, 1);
        repeat (3) @(negedge Clk);
        check({tag, "_done_count"}, done_cnt, 1);
        check({tag, "_done_after_last_byte"}, done_cyc > last_xfer, 1);
        check({tag, "_idle_after"}, Busy, 0);
        check({tag, "_mem_wr"}, bad_wr, 0);
        check({tag, "_nbytes"}, got_q.size(), exp_q.size());
        if (exp_bytes != 0) check({tag, "_nbytes_tbl"}, got_q.size(), exp_bytes);
        if (exp_busy != 0) check({tag, "_busy_cycles"}, busy_cyc, exp_busy);
        for (int unsigned i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            n_cmp++;
            if (got_q[i] != exp_q[i]) begin
                n_fail++;
                $display("FAIL %s_byte[%0d]: got %02h expected %02h", tag, i, got_q[i], exp_q[i]);
                break;
            end
        end
        check({tag, "_nreads"}, rd_q.size(), last + 1);
        for (int unsigned i = 0; i < rd_q.size(); i++) begin
            n_cmp++;
            if (rd_q[i] != AW'(i)) begin
                n_fail++;
                $display("FAIL %s_rd_addr[%0d]: got %0h expected %0h", tag, i, rd_q[i], i);
                break;
            end
        end
    endtask

    typedef struct {
        int unsigned last;
        int unsigned exp_bytes;
        int unsigned exp_busy;
    } vec_t;

    initial begin
        vec_t tbl[4];
        bit   found;

        tbl[0] = '{last: 0,    exp_bytes: 2    + CHK_X, exp_busy: 4    + CHK_X};
        tbl[1] = '{last: 1,    exp_bytes: 4    + CHK_X, exp_busy: 7    + CHK_X};
        tbl[2] = '{last: 4,    exp_bytes: 10   + CHK_X, exp_busy: 16   + CHK_X};
        tbl[3] = '{last: 2047, exp_bytes: 4096 + CHK_X, exp_busy: 6145 + CHK_X};

        rmode = 0;
        Reset = 1'b0;
        Start = 1'b0;
        Last_Addr = '0;
        for (int unsigned a = 0; a < 2**AW; a++) mem[a] = DW'($urandom);
        mem[0] = 16'h1234;
        mem[1] = 16'hABCD;

        repeat (2) @(negedge Clk);
        check("rst_mem_rd", Mem_Rd, 0);
        check("rst_mem_addr", Mem_Addr, 0);
        check("rst_tx_valid", Tx_Valid, 0);
        check("rst_tx_data", Tx_Data, 0);
        check("rst_busy", Busy, 0);
        check("rst_done", Done, 0);
        check("rst_mem_wr", Mem_Wr, 0);
        @(posedge Clk);
        #1;
        Reset = 1'b1;

        // Two-word dump 0x1234, 0xABCD with the transmitter always ready.
        run_dump("basic", 1, 0, 1'b0, 4 + CHK_X, 7 + CHK_X);

        for (int unsigned t = 0; t < 4; t++) begin
            run_dump($sformatf("tbl%0d", t), tbl[t].last, 0, 1'b0, tbl[t].exp_bytes, tbl[t].exp_busy);
        end

        mem[0] = 16'hBEEF;
        run_dump("stall", 0, 1, 1'b0, 2 + CHK_X, 0);

        run_dump("ignore_start", 3, 0, 1'b1, 8 + CHK_X, 13 + CHK_X);

        // Reset while the second byte of word 5 is being offered.
        rmode = 0;
        clear_mon();
        @(posedge Clk);
        #1;
        Start = 1'b1;
        Last_Addr = AW'(9);
        @(posedge Clk);
        #1;
        Start = 1'b0;
        found = 1'b0;
        for (int unsigned c = 0; c < 200; c++) begin
            @(posedge Clk);
            #2;
            if (got_q.size() == 11 && Tx_Valid) begin
                found = 1'b1;
                break;
            end
        end
        check("midrst_reached", found, 1);
        check("midrst_addr_before", Mem_Addr, 5);
        Reset = 1'b0;
        #1;
        check("midrst_tx_valid", Tx_Valid, 0);
        check("midrst_busy", Busy, 0);
        check("midrst_mem_rd", Mem_Rd, 0);
        check("midrst_mem_addr", Mem_Addr, 0);
        check("midrst_tx_data", Tx_Data, 0);
        @(posedge Clk);
        #1;
        Reset = 1'b1;
        run_dump("post_rst", 0, 0, 1'b0, 2 + CHK_X, 4 + CHK_X);

        for (int unsigned r = 0; r < 8; r++) begin
            for (int unsigned a = 0; a < 16; a++) mem[a] = DW'($urandom);
            run_dump($sformatf("rnd%0d", r), $urandom_range(0, 15), 2, r[0], 0, 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_dump_ctrl.md
MEM_DUMP_CTRL -- requirements
Module: mem_dump_ctrl

Interface
REQ-001 Parameters SHALL be: addr_bus, default 11, data memory address width; data_size, default 16, data memory word width (multiple of 8).
REQ-002 Clk  input  1  single clock; all state changes on rising edge.
REQ-003 Reset  input  1  reset, asynchronous assertion, active-low (0 = reset).
REQ-004 Start  input  1  one-cycle request to begin a dump; sampled only in IDLE.
REQ-005 Last_Addr  input  addr_bus  final word address to dump; captured on accepted Start.
REQ-006 Mem_Rd  output  1  read strobe to data memory.
REQ-007 Mem_Wr  output  1  write strobe to data memory; constant 0.
REQ-008 Mem_Addr  output  addr_bus  data memory address.
REQ-009 Mem_In_Data  output  data_size  data memory write data; constant 0.
REQ-010 Mem_Out_Data  input  data_size  data memory read data, combinationally valid while Mem_Rd=1.
REQ-011 Tx_Data  output  8  byte to serial transmitter.
REQ-012 Tx_Valid  output  1  Tx_Data holds a byte to send.
REQ-013 Tx_Ready  input  1  transmitter accepts byte; transfer occurs on a cycle with Tx_Valid=1 and Tx_Ready=1.
REQ-014 Busy  output  1  dump in progress (any state except IDLE).
REQ-015 Done  output  1  one-cycle pulse when the final byte has transferred.

Function
REQ-016 FSM states SHALL be IDLE, READ, SEND, DONE (plus CHK when checksum is compiled in).
REQ-017 IDLE: Start=1 -> READ; address counter <= 0; last register <= Last_Addr; byte index <= 0.
REQ-018 READ (one cycle): Mem_Rd=1, Mem_Addr=address counter; word register <= Mem_Out_Data at the cycle's end; -> SEND.
REQ-019 Mem_Rd SHALL be 0 in every state except READ; Mem_Addr SHALL hold the counter value at all times.
REQ-020 SEND: Tx_Valid=1, Tx_Data = byte of word register selected by byte index, MSB byte first.
REQ-021 Tx_Data SHALL remain stable while Tx_Valid=1 and Tx_Ready=0; stall length unbounded.
REQ-022 On transfer with byte index < data_size/8-1: byte index +1, stay in SEND.
REQ-023 On transfer of last byte: if counter == last register -> DONE (or CHK), else counter +1, byte index <= 0, -> READ.
REQ-024 Counter SHALL never wrap: Last_Addr = 2**addr_bus-1 ends after that address; Last_Addr=0 dumps exactly one word.
REQ-025 DONE (one cycle): Done=1 -> IDLE; Start in DONE SHALL be ignored.
REQ-026 Start while Busy=1 SHALL be ignored; Last_Addr changes after capture SHALL have no effect.
REQ-027 Per word: 1 READ cycle + data_size/8 transfers; no idle cycles when Tx_Ready held 1.

Reset
REQ-028 Reset=0 SHALL force IDLE immediately, including mid-dump; abandoned bytes SHALL NOT be resumed.
REQ-029 Reset values: Mem_Rd=0, Mem_Addr=0, Tx_Valid=0, Tx_Data=0, Busy=0, Done=0, all counters and word/checksum registers 0.

Configuration
REQ-030 Macro MEM_DUMP_CHECKSUM_EN defined: byte-wise XOR of all dumped bytes accumulated; after last word the FSM SHALL enter CHK, present the checksum as one extra byte under REQ-021 handshake, then DONE.
REQ-031 MEM_DUMP_CHECKSUM_EN undefined: no CHK state, no checksum register; last word transfer goes directly to DONE.

Structure
REQ-032 A shared package SHALL hold the FSM state enumeration and the default widths (11, 16).
REQ-033 Sub-module mem_dump_byte_sel SHALL implement the word-register byte selection (word + index -> byte); all else in mem_dump_ctrl.

Verification
REQ-034 Mem preloaded 0x1234, 0xABCD; Start, Last_Addr=1, Tx_Ready=1 -> bytes 12,34,AB,CD, Done pulse after CD, Mem_Wr never 1.
REQ-035 Last_Addr=0, word 0xBEEF, Tx_Ready toggled every 3 cycles -> bytes BE,EF only, each stable through stall, Done once.
REQ-036 Reset=0 during second byte of word 5 -> Tx_Valid=0, Busy=0 same cycle; new Start restarts at address 0.
REQ-037 Start pulsed while Busy and Last_Addr changed mid-dump -> byte count and final address unchanged from original request.
REQ-038 With MEM_DUMP_CHECKSUM_EN, words 0x1234, 0xABCD -> extra byte 0x12^0x34^0xAB^0xCD = 0x40 before Done; without macro, no extra byte.
